tvm_input_frontend: RTL

Upstream input stage of the ticket vending machine controller. It synchronises and debounces the raw coin-acceptor sensors, station buttons and the cancel key, and converts each accepted press or coin into one non-zero 8-bit event code. Codes are queued in a 4-entry FIFO and presented on the controller's data input until the controller acknowledges them, so no event is consumed twice or lost while the controller is busy in another state. It also produces the one-cycle cancel pulse that drives the controller's reset-button input.

---
 rtl/tvm_pkg.sv | 27 ++
 rtl/tvm_debounce_ch.sv | 47 ++++
 rtl/tvm_input_frontend.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tvm_pkg.sv
// Event codes and channel numbering shared by the vending machine input front end.
package tvm_pkg;

    localparam int NUM_COIN = 3;
    localparam int NUM_BUT  = 8;
    localparam int NUM_EVT  = NUM_COIN + NUM_BUT;

    typedef logic [7:0] evt_code_t;

    localparam evt_code_t CODE_COIN1    = 8'h01;
    localparam evt_code_t CODE_COIN5    = 8'h05;
    localparam evt_code_t CODE_COIN10   = 8'h0A;
    localparam evt_code_t CODE_BUT_BASE = 8'h80;

    // Channel index: coins first, then buttons, which is also the enqueue priority.
    function automatic evt_code_t evt_code(input int unsigned idx);
        evt_code_t c;
        case (idx)
            0:       c = CODE_COIN1;
            1:       c = CODE_COIN5;
            2:       c = CODE_COIN10;
            default: c = CODE_BUT_BASE | evt_code_t'(idx - NUM_COIN);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tvm_debounce_ch.sv
// One sensor channel: 2-FF synchroniser, stable counter, accepted level and rising-edge pulse.
// rst_i is active-low and synchronous.
module tvm_debounce_ch #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic acc_o,
    output logic rise_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       acc_q;
    logic       rise_q;
    logic [7:0] cnt_q;
    logic       hit;

    assign hit = (sync2_q != acc_q) && (cnt_q == 8'(DEB_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            acc_q   <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            rise_q  <= hit && !acc_q;
            if (sync2_q == acc_q) begin
                cnt_q <= '0;
            end else if (hit) begin
                acc_q <= ~acc_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign acc_o  = acc_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/tvm_input_frontend.sv
// Input front end: debounces coin/button/cancel sensors and queues one event
// code per accepted press until the vending controller acknowledges it.
module tvm_input_frontend
    import tvm_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin_raw,
    input  logic [7:0] but_raw,
    input  logic       cancel_raw,
    input  logic       ack,
    output logic [7:0] data_out,
    output logic       cancel_out,
    output logic [2:0] jam,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_COIN-1:0] coin_acc;
    logic [NUM_BUT:0]    acc_unused;
    logic [NUM_EVT-1:0]  rise;
    logic                cancel_rise;

    for (genvar g = 0; g < NUM_COIN; g++) begin : g_coin
        tvm_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i(clk), .rst_i(rst), .raw_i(coin_raw[g]),
            .acc_o(coin_acc[g]), .rise_o(rise[g])
        );
    end

    for (genvar g = 0; g < NUM_BUT; g++) begin : g_but
        tvm_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i(clk), .rst_i(rst), .raw_i(but_raw[g]),
            .acc_o(acc_unused[g]), .rise_o(rise[NUM_COIN+g])
        );
    end

    tvm_debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cancel (
        .clk_i(clk), .rst_i(rst), .raw_i(cancel_raw),
        .acc_o(acc_unused[NUM_BUT]), .rise_o(cancel_rise)
    );

    logic [15:0]         jam_cnt_q [NUM_COIN];
    logic [NUM_COIN-1:0] jam_q;
    logic [NUM_EVT-1:0]  pend_q, pend_d, ev, clr;
    logic                overflow_q, overflow_d;
    logic                cancel_q;
    evt_code_t           mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    evt_code_t           head_q, head_d, wdata;
    logic                pop, push, sel_valid;
    logic [3:0]          sel_idx;

    // Jam timer reloads while the coin is low and counts down while it is held.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COIN; i++) begin
            if (!rst) begin
                jam_cnt_q[i] <= '0;
                jam_q[i]     <= 1'b0;
            end else if (!coin_acc[i]) begin
                jam_cnt_q[i] <= 16'(JAM_CYCLES - 1);
                jam_q[i]     <= 1'b0;
            end else if (!jam_q[i]) begin
                if (jam_cnt_q[i] == '0) jam_q[i] <= 1'b1;
                else                    jam_cnt_q[i] <= jam_cnt_q[i] - 16'd1;
            end
        end
    end

    assign ev = rise & ~{{NUM_BUT{1'b0}}, jam_q};

    always_comb begin
        pop       = ack && (count_q != '0);
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_EVT - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 4'(i);
            end
        end
        push = sel_valid && ((count_q != CW'(FIFO_DEPTH)) || pop);
        clr  = '0;
        if (push) clr[sel_idx] = 1'b1;
        pend_d     = (pend_q & ~clr) | ev;
        overflow_d = overflow_q | (|(ev & pend_q & ~clr));
        wdata      = evt_code({28'd0, sel_idx});
        count_d    = count_q + CW'(push) - CW'(pop);
        // Head register follows the queue's next state so data_out needs no extra cycle.
        head_d = 8'h00;
        if (count_d != '0) begin
            if ((count_q - CW'(pop)) == '0) head_d = wdata;
            else                            head_d = mem_q[rd_ptr_q + PW'(pop)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q     <= '0;
            overflow_q <= 1'b0;
            cancel_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= 8'h00;
        end else begin
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            cancel_q   <= cancel_rise;
            count_q    <= count_d;
            head_q     <= head_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign data_out   = head_q;
    assign cancel_out = cancel_q;
    assign jam        = jam_q;
    assign overflow   = overflow_q;

endmodule
